// File: rtl/tetron_collision_checker.sv
// rtl/tetron_collision_checker.sv - bounds-checks four tetron blocks and probes board occupancy for a collision verdict
// Optional macro: TETRON_CHK_EARLY_EXIT_EN stops the check at the first colliding block.
module tetron_collision_checker #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] origin_row,
    input  logic [4:0] origin_col,
    input  logic [4:0] blk1_voffset,
    input  logic [4:0] blk2_voffset,
    input  logic [4:0] blk3_voffset,
    input  logic [4:0] blk4_voffset,
    input  logic [4:0] blk1_hoffset,
    input  logic [4:0] blk2_hoffset,
    input  logic [4:0] blk3_hoffset,
    input  logic [4:0] blk4_hoffset,
    output logic       board_rd_en,
    output logic [4:0] board_rd_row,
    output logic [3:0] board_rd_col,
    input  logic       board_rd_data,
    output logic       busy,
    output logic       done,
    output logic       collision,
    output logic       oob,
    output logic [3:0] hit_mask
);

    typedef enum logic [1:0] {IDLE, REQ, EVAL, DONE} state_t;

    state_t     r_state, w_state_nxt;
    logic [4:0] r_orow, r_ocol;
    logic [4:0] r_voff [4];
    logic [4:0] r_hoff [4];
    logic [1:0] r_idx, w_idx_nxt, w_idx_inc;
    logic       r_blk_oob, w_blk_oob_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic       r_rd_en, w_rd_en_nxt;
    logic [4:0] r_rd_row, w_rd_row_nxt;
    logic [3:0] r_rd_col, w_rd_col_nxt;
    logic       r_coll, w_coll_nxt;
    logic       r_oob, w_oob_nxt;
    logic [3:0] r_hit, w_hit_nxt;

    logic [4:0] w_org_row, w_org_col, w_voff, w_hoff;
    logic [5:0] w_row, w_col;
    logic       w_inb, w_issue, w_finish, w_hit_now;

    assign w_idx_inc = r_idx + 2'd1;

    // Block 1 is addressed straight from the ports so its read issues on the accept edge.
    always_comb begin
        if (r_state == IDLE) begin
            w_org_row = origin_row;
            w_org_col = origin_col;
            w_voff    = blk1_voffset;
            w_hoff    = blk1_hoffset;
        end else begin
            w_org_row = r_orow;
            w_org_col = r_ocol;
            w_voff    = r_voff[w_idx_inc];
            w_hoff    = r_hoff[w_idx_inc];
        end
    end

    assign w_row = {1'b0, w_org_row} + {w_voff[4], w_voff};
    assign w_col = {1'b0, w_org_col} + {w_hoff[4], w_hoff};
    assign w_inb = !w_row[5] && (w_row < 6'(BOARD_H)) && !w_col[5] && (w_col < 6'(BOARD_W));
    assign w_hit_now = r_blk_oob | board_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_blk_oob_nxt = r_blk_oob;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_rd_row_nxt  = r_rd_row;
        w_rd_col_nxt  = r_rd_col;
        w_coll_nxt    = r_coll;
        w_oob_nxt     = r_oob;
        w_hit_nxt     = r_hit;
        w_issue       = 1'b0;
        w_finish      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = REQ;
                    w_busy_nxt  = 1'b1;
                    w_idx_nxt   = 2'd0;
                    w_coll_nxt  = 1'b0;
                    w_oob_nxt   = 1'b0;
                    w_hit_nxt   = 4'd0;
                    w_issue     = 1'b1;
                end
            end
            REQ: begin
                w_state_nxt = (r_idx == 2'd3) ? DONE : EVAL;
            end
            EVAL, DONE: begin
                if (w_hit_now) begin
                    w_hit_nxt[r_idx] = 1'b1;
                    w_coll_nxt       = 1'b1;
                    if (r_blk_oob) begin
                        w_oob_nxt = 1'b1;
                    end
                end
                w_finish = (r_state == DONE);
`ifdef TETRON_CHK_EARLY_EXIT_EN
                if (w_hit_now) begin
                    w_finish = 1'b1;
                end
`endif
                if (w_finish) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = REQ;
                    w_idx_nxt   = w_idx_inc;
                    w_issue     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Out-of-bounds blocks skip the memory and are flagged when evaluated.
        if (w_issue) begin
            w_rd_en_nxt   = w_inb;
            w_blk_oob_nxt = !w_inb;
            if (w_inb) begin
                w_rd_row_nxt = w_row[4:0];
                w_rd_col_nxt = w_col[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_orow    <= 5'd0;
            r_ocol    <= 5'd0;
            for (int i = 0; i < 4; i++) begin
                r_voff[i] <= 5'd0;
                r_hoff[i] <= 5'd0;
            end
            r_idx     <= 2'd0;
            r_blk_oob <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_row  <= 5'd0;
            r_rd_col  <= 4'd0;
            r_coll    <= 1'b0;
            r_oob     <= 1'b0;
            r_hit     <= 4'd0;
        end else begin
            if (r_state == IDLE && start) begin
                r_orow    <= origin_row;
                r_ocol    <= origin_col;
                r_voff[0] <= blk1_voffset;
                r_voff[1] <= blk2_voffset;
                r_voff[2] <= blk3_voffset;
                r_voff[3] <= blk4_voffset;
                r_hoff[0] <= blk1_hoffset;
                r_hoff[1] <= blk2_hoffset;
                r_hoff[2] <= blk3_hoffset;
                r_hoff[3] <= blk4_hoffset;
            end
            r_idx     <= w_idx_nxt;
            r_blk_oob <= w_blk_oob_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_row  <= w_rd_row_nxt;
            r_rd_col  <= w_rd_col_nxt;
            r_coll    <= w_coll_nxt;
            r_oob     <= w_oob_nxt;
            r_hit     <= w_hit_nxt;
        end
    end

    assign board_rd_en  = r_rd_en;
    assign board_rd_row = r_rd_row;
    assign board_rd_col = r_rd_col;
    assign busy         = r_busy;
    assign done         = r_done;
    assign collision    = r_coll;
    assign oob          = r_oob;
    assign hit_mask     = r_hit;

endmodule

// File: tb/tb_tetron_collision_checker.sv
// tb/tb_tetron_collision_checker.sv - self-checking bench for tetron_collision_checker
module tb_tetron_collision_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] origin_row = 5'd0;
    logic [4:0] origin_col = 5'd0;
    logic [4:0] vo [4];
    logic [4:0] ho [4];
    logic       board_rd_en;
    logic [4:0] board_rd_row;
    logic [3:0] board_rd_col;
    logic       board_rd_data = 1'b0;
    logic       busy, done, collision, oob;
    logic [3:0] hit_mask;

    bit         board [20][10];
    int         rd_q [$];
    int         exp_reads [$];
    int         exp_lat;
    logic [3:0] exp_hit;
    logic       exp_oob;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    tetron_collision_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .origin_row(origin_row), .origin_col(origin_col),
        .blk1_voffset(vo[0]), .blk2_voffset(vo[1]), .blk3_voffset(vo[2]), .blk4_voffset(vo[3]),
        .blk1_hoffset(ho[0]), .blk2_hoffset(ho[1]), .blk3_hoffset(ho[2]), .blk4_hoffset(ho[3]),
        .board_rd_en(board_rd_en), .board_rd_row(board_rd_row), .board_rd_col(board_rd_col),
        .board_rd_data(board_rd_data), .busy(busy), .done(done),
        .collision(collision), .oob(oob), .hit_mask(hit_mask)
    );

    // Board memory with one cycle of read latency.
    always @(posedge clk) begin
        if (board_rd_en && board_rd_row < 5'd20 && board_rd_col < 4'd10)
            board_rd_data <= board[board_rd_row][board_rd_col];
        else
            board_rd_data <= 1'b0;
    end

    always @(negedge clk) begin
        if (board_rd_en) rd_q.push_back(int'(board_rd_row) * 16 + int'(board_rd_col));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_board();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) board[r][c] = 1'b0;
    endtask

    task automatic set_shape(input int orow, input int ocol, input int v0, input int v1, input int v2,
                             input int v3, input int h0, input int h1, input int h2, input int h3);
        origin_row = orow[4:0];
        origin_col = ocol[4:0];
        vo[0] = v0[4:0]; vo[1] = v1[4:0]; vo[2] = v2[4:0]; vo[3] = v3[4:0];
        ho[0] = h0[4:0]; ho[1] = h1[4:0]; ho[2] = h2[4:0]; ho[3] = h3[4:0];
    endtask

    // Reference: walk the blocks in order using plain integer coordinates.
    task automatic model();
        exp_hit = 4'd0;
        exp_oob = 1'b0;
        exp_lat = 8;
        exp_reads.delete();
        for (int k = 0; k < 4; k++) begin
            int  r, c;
            bit  out, hit;
            r   = int'(origin_row) + int'($signed(vo[k]));
            c   = int'(origin_col) + int'($signed(ho[k]));
            out = (r < 0) || (r >= 20) || (c < 0) || (c >= 10);
            hit = out;
            if (!out) begin
                exp_reads.push_back(r * 16 + c);
                hit = board[r][c];
            end
            if (hit) begin
                exp_hit[k] = 1'b1;
                if (out) exp_oob = 1'b1;
`ifdef TETRON_CHK_EARLY_EXIT_EN
                exp_lat = 2 * (k + 1);
                break;
`endif
            end
        end
    endtask

    task automatic check_verdict(input string tag);
        chk({tag, ".coll"}, {31'd0, collision}, {31'd0, exp_hit != 4'd0});
        chk({tag, ".oob"}, {31'd0, oob}, {31'd0, exp_oob});
        chk({tag, ".hit"}, {28'd0, hit_mask}, {28'd0, exp_hit});
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk({tag, ".lat"}, lat, exp_lat);
    endtask

    task automatic run(input string tag, input bit mid_pulse);
        int lat;
        model();
        rd_q.delete();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk({tag, ".busy_acc"}, {31'd0, busy}, 32'd1);
        chk({tag, ".coll_clr"}, {31'd0, collision}, 32'd0);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            start = mid_pulse && (i == 2);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
        check_verdict(tag);
        chk({tag, ".rd_cnt"}, rd_q.size(), exp_reads.size());
        for (int i = 0; i < exp_reads.size() && i < rd_q.size(); i++)
            chk({tag, ".rd_addr"}, rd_q[i], exp_reads[i]);
        @(posedge clk); #1;
        chk({tag, ".done_w"}, {31'd0, done}, 32'd0);
        chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
        check_verdict({tag, ".held"});
    endtask

    initial begin
        int lat;
        clear_board();
        set_shape(5, 4, 0, 0, 0, 0, 0, -1, 1, 2);
        repeat (2) @(posedge clk); #1;
        chk("reset.outs", {busy, done, board_rd_en, collision, oob, hit_mask, board_rd_row, board_rd_col}, 0);
        @(negedge clk); rst_n = 1'b1;

        run("s1", 1'b0);
        board[5][6] = 1'b1;
        run("s2", 1'b0);
        clear_board();
        set_shape(5, 8, 0, 0, 0, 0, 0, -1, 1, 2);
        run("s3", 1'b0);
        set_shape(0, 4, 0, -1, 1, 2, 0, 0, 0, 0);
        run("s4", 1'b0);
        board[7][3] = 1'b1;
        set_shape(7, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        run("dup", 1'b0);
        clear_board();

        // Reset in the middle of a check.
        set_shape(5, 4, 0, 0, 0, 0, 0, -1, 1, 2);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        chk("s5.rst_outs", {busy, done, board_rd_en, collision, oob, hit_mask, board_rd_row, board_rd_col}, 0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("s5.no_done", {31'd0, done}, 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        run("s5.after", 1'b0);

        // start held high: accepts at E0 and E9.
        board[5][3] = 1'b1;
        model();
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        chk("s6.done8", {31'd0, done}, {31'd0, exp_lat == 8});
        chk("s6.busy8", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("s6.reaccept", {31'd0, busy}, 32'd1);
        chk("s6.done9", {31'd0, done}, 32'd0);
        start = 1'b0;
        wait_done("s6.second", lat);
        check_verdict("s6.second");
        repeat (3) @(posedge clk);
        #1;
        chk("s6.idle", {31'd0, busy}, 32'd0);
        check_verdict("s6.hold");
        run("s6.pulse", 1'b1);
        clear_board();

        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 20; r++)
                for (int c = 0; c < 10; c++) board[r][c] = ($urandom_range(0, 99) < 15);
            set_shape($urandom_range(0, 21), $urandom_range(0, 11),
                      int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3,
                      int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3,
                      int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3,
                      int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3);
            run("rand", ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
